// File: rtl/csr_bringup_master.sv
// ---------------------------------------------------------------------------
// csr_bringup_master
//
// Avalon-MM initiator that brings up one Ethernet port through the user-space
// CSR responder. The sequence runs on a start pulse:
//   1. write ASSERT_DATA to CONTROL_REG (port resets asserted)
//   2. wait HOLD_CYCLES
//   3. write RELEASE_DATA to CONTROL_REG (port resets released)
//   4. poll STATUS_REG every POLL_GAP idle cycles until all READY_MASK bits
//      read 1, or MAX_POLLS polls are exhausted.
// Every bus phase is guarded by a RSP_TIMEOUT cycle response timer.
//
// Ports
//   csr_clk          clock
//   reset            synchronous, active-low; clears state and all outputs
//   start            one-cycle pulse, honoured only in IDLE, DONE or FAIL
//   csr_address      Avalon word address
//   csr_write        write request
//   csr_read         read request
//   csr_wr_data      write data
//   csr_byteenable   4'hF while a request is active, else 4'h0
//   csr_waitrequest  responder stall
//   csr_rd_data      read data
//   csr_rd_vld       read data valid
//   busy             sequence in progress
//   done             sticky success
//   fail             sticky failure
//   fail_code        01 = poll limit, 10 = bus response timeout, 00 = none
//   last_status      most recent STATUS read data
//   poll_count       polls issued this run, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module csr_bringup_master #(
  parameter logic [11:0] CTRL_ADDR    = 12'h010,
  parameter logic [11:0] STATUS_ADDR  = 12'h020,
  parameter logic [31:0] ASSERT_DATA  = 32'h0000_0000,
  parameter logic [31:0] RELEASE_DATA = 32'h0000_0007,
  parameter logic [31:0] READY_MASK   = 32'h0000_0155,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned POLL_GAP     = 64,
  parameter int unsigned MAX_POLLS    = 1000,
  parameter int unsigned RSP_TIMEOUT  = 32
) (
  input  logic        csr_clk,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] csr_address,
  output logic        csr_write,
  output logic        csr_read,
  output logic [31:0] csr_wr_data,
  output logic [3:0]  csr_byteenable,
  input  logic        csr_waitrequest,
  input  logic [31:0] csr_rd_data,
  input  logic        csr_rd_vld,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [31:0] last_status,
  output logic [15:0] poll_count
);

  typedef enum logic [3:0] {
    IDLE, WR_ASSERT, HOLD, WR_RELEASE, RD_REQ, RD_WAIT, GAP, DONE, FAIL
  } state_t;

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > POLL_GAP) ? HOLD_CYCLES : POLL_GAP;
  localparam int unsigned TW      = $clog2(RSP_TIMEOUT) + 1;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(RSP_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(POLL_GAP - 1);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_POLLS = 2'b01;
  localparam logic [1:0] CODE_TMO   = 2'b10;

  state_t        state, state_nxt;
  logic [TW-1:0] rsp_timer;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    fail_code_nxt;
  logic          accepted;
  logic          ready_hit;
  logic          poll_limit;
  logic          timed_state;
  logic          timeout;
  logic          can_start;
  logic          state_change;

  assign accepted     = (csr_write | csr_read) & ~csr_waitrequest;
  assign ready_hit    = (csr_rd_data & READY_MASK) == READY_MASK;
  assign poll_limit   = {16'h0000, poll_count} >= MAX_POLLS;
  assign timed_state  = state inside {WR_ASSERT, WR_RELEASE, RD_REQ, RD_WAIT};
  assign timeout      = timed_state && (rsp_timer == TMO_LAST);
  assign can_start    = start && (state inside {IDLE, DONE, FAIL});
  assign state_change = (state_nxt != state);

  // Next-state logic. Accepted transfers and valid read data take priority
  // over a response timeout landing on the same edge.
  always_comb begin
    state_nxt     = state;
    fail_code_nxt = fail_code;
    case (state)
      IDLE, DONE, FAIL: begin
        if (start) begin
          state_nxt     = WR_ASSERT;
          fail_code_nxt = CODE_NONE;
        end
      end
      WR_ASSERT: begin
        if (accepted) begin
          state_nxt = HOLD;
        end else if (timeout) begin
          state_nxt     = FAIL;
          fail_code_nxt = CODE_TMO;
        end
      end
      HOLD: begin
        if (wait_cnt == HOLD_LAST) state_nxt = WR_RELEASE;
      end
      WR_RELEASE: begin
        if (accepted) begin
          state_nxt = RD_REQ;
        end else if (timeout) begin
          state_nxt     = FAIL;
          fail_code_nxt = CODE_TMO;
        end
      end
      RD_REQ: begin
        if (accepted) begin
          state_nxt = RD_WAIT;
        end else if (timeout) begin
          state_nxt     = FAIL;
          fail_code_nxt = CODE_TMO;
        end
      end
      RD_WAIT: begin
        if (csr_rd_vld) begin
          if (ready_hit) begin
            state_nxt = DONE;
          end else if (poll_limit) begin
            state_nxt     = FAIL;
            fail_code_nxt = CODE_POLLS;
          end else begin
            state_nxt = GAP;
          end
        end else if (timeout) begin
          state_nxt     = FAIL;
          fail_code_nxt = CODE_TMO;
        end
      end
      GAP: begin
        if (wait_cnt == GAP_LAST) state_nxt = RD_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered bus outputs. Requests are a function of
  // the next state, so they stay put (stable) while waitrequest holds the
  // FSM in a request state and drop on the edge after acceptance.
  always_ff @(posedge csr_clk) begin
    if (!reset) begin
      state          <= IDLE;
      rsp_timer      <= '0;
      wait_cnt       <= '0;
      csr_address    <= '0;
      csr_write      <= 1'b0;
      csr_read       <= 1'b0;
      csr_wr_data    <= '0;
      csr_byteenable <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      fail_code      <= CODE_NONE;
      last_status    <= '0;
      poll_count     <= '0;
    end else begin
      state     <= state_nxt;
      fail_code <= fail_code_nxt;

      rsp_timer <= (timed_state && !state_change) ? rsp_timer + TW'(1) : '0;
      wait_cnt  <= state_change ? '0 : wait_cnt + CW'(1);

      csr_write      <= state_nxt inside {WR_ASSERT, WR_RELEASE};
      csr_read       <= (state_nxt == RD_REQ);
      csr_byteenable <= (state_nxt inside {WR_ASSERT, WR_RELEASE, RD_REQ}) ? 4'hF : 4'h0;
      csr_address    <= (state_nxt inside {WR_ASSERT, WR_RELEASE}) ? CTRL_ADDR :
                        (state_nxt == RD_REQ)                    ? STATUS_ADDR : 12'h000;
      csr_wr_data    <= (state_nxt == WR_ASSERT)  ? ASSERT_DATA :
                        (state_nxt == WR_RELEASE) ? RELEASE_DATA : 32'h0;
      busy           <= state_nxt inside {WR_ASSERT, HOLD, WR_RELEASE, RD_REQ, RD_WAIT, GAP};

      if (can_start) begin
        done       <= 1'b0;
        fail       <= 1'b0;
        poll_count <= '0;
      end else begin
        if (state == RD_REQ && accepted && poll_count != 16'hFFFF)
          poll_count <= poll_count + 16'd1;
        if (state_nxt == DONE && state != DONE) done <= 1'b1;
        if (state_nxt == FAIL && state != FAIL) fail <= 1'b1;
      end

      if (state == RD_WAIT && csr_rd_vld) last_status <= csr_rd_data;
    end
  end

endmodule
